bus_chipset: RTL and testbench

// - Parametrised memory-map interconnect between CPU data port and NSLV data slaves (RAM, message ROM, I/O).
// - Decodes address into one-hot slave selects.
// - Stretches reads by a per-slave latency via a stall handshake, and returns registered read data.
// - Flags unmapped accesses. Replaces a fixed 2-way decoder plus external read mux.

---
 rtl/bus_chipset.sv | 215 +++++++++++++++++++++
 tb/tb_bus_chipset.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_chipset.sv
// ---------------------------------------------------------------------------
// bus_chipset
//   Memory-map interconnect between the CPU data port and NSLV data slaves.
//   Decodes the CPU address into a one-hot slave select and stretches reads
//   by a per-slave latency using a stall handshake. Data from a stretched
//   read is returned from a register. Accesses that hit no region are flagged.
//
//   Optional feature macro: CHIPSET_ERRCNT_EN
//     defined   -> 16-bit saturating count of unmapped accesses. A write with
//                  addr[AW-1]=1 clears it, and the clear wins over a same-cycle
//                  increment.
//     undefined -> err_cnt is tied to zero and no counter flops exist.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   req        in   1        CPU access valid this cycle
//   we         in   1        1=write, 0=read
//   addr       in   AW       CPU byte address
//   wdata      in   DW       CPU write data
//   rdata      out  DW       read data to CPU
//   stall      out  1        CPU must hold its request and not advance
//   err        out  1        one-cycle pulse after an unmapped access
//   err_cnt    out  16       unmapped-access count (zero without the macro)
//   slv_sel    out  NSLV     one-hot slave enable
//   slv_we     out  1        write strobe to the selected slave
//   slv_addr   out  AW       address to slaves (= addr)
//   slv_wdata  out  DW       write data to slaves (= wdata)
//   slv_rdata  in   NSLV*DW  slave read buses, slave i at [i*DW +: DW]
// ---------------------------------------------------------------------------
module bus_chipset #(
    parameter int                 AW       = 32,
    parameter int                 DW       = 32,
    parameter int                 NSLV     = 3,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h0000_1000, 32'h0000_0800, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_FF80, 32'hFFFF_F800},
    parameter logic [NSLV*4-1:0]  SLV_LAT  = {4'd0, 4'd2, 4'd1}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      wdata,
    output logic [DW-1:0]      rdata,
    output logic               stall,
    output logic               err,
    output logic [15:0]        err_cnt,
    output logic [NSLV-1:0]    slv_sel,
    output logic               slv_we,
    output logic [AW-1:0]      slv_addr,
    output logic [DW-1:0]      slv_wdata,
    input  logic [NSLV*DW-1:0] slv_rdata
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [IW-1:0]   r_sidx, w_sidx_nxt;
    logic [IW-1:0]   w_hit_idx;
    logic            w_hit;
    logic [3:0]      w_hit_lat;
    logic [3:0]      w_sidx_lat;
    logic [DW-1:0]   r_rdata_q, w_cap_data;
    logic            w_cap;
    logic            r_err, w_miss;

    // Address decode: scan from the top index down so the lowest matching
    // index is the one left standing on overlapping regions.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                w_hit     = 1'b1;
                w_hit_idx = i[IW-1:0];
            end
        end
    end

    assign w_hit_lat  = SLV_LAT[w_hit_idx*4 +: 4];
    assign w_sidx_lat = SLV_LAT[r_sidx*4 +: 4];

    // Next state and outputs. A stretched read stalls exactly L cycles: the
    // launch cycle in IDLE is the first one, WAIT supplies the remaining L-1,
    // and the data is presented in DONE. r_cnt counts stall cycles already
    // spent, so a latency-1 read skips WAIT and captures at the launch edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sidx_nxt  = r_sidx;
        w_cap       = 1'b0;
        w_cap_data  = slv_rdata[r_sidx*DW +: DW];
        w_miss      = 1'b0;
        stall       = 1'b0;
        slv_sel     = '0;
        slv_we      = 1'b0;
        rdata       = r_rdata_q;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (!w_hit) begin
                        w_miss = 1'b1;
                        if (!we) rdata = '0;
                    end else begin
                        slv_sel[w_hit_idx] = 1'b1;
                        if (we) begin
                            slv_we = 1'b1;
                        end else if (w_hit_lat == 4'd0) begin
                            rdata = slv_rdata[w_hit_idx*DW +: DW];
                        end else begin
                            stall      = 1'b1;
                            w_sidx_nxt = w_hit_idx;
                            if (w_hit_lat == 4'd1) begin
                                w_cap       = 1'b1;
                                w_cap_data  = slv_rdata[w_hit_idx*DW +: DW];
                                w_state_nxt = S_DONE;
                            end else begin
                                w_cnt_nxt   = 4'd1;
                                w_state_nxt = S_WAIT;
                            end
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    // CPU abandoned the read: release without capturing.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    slv_sel[r_sidx] = 1'b1;
                    stall           = 1'b1;
                    if (r_cnt == w_sidx_lat - 4'd1) begin
                        w_cap       = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            S_DONE: begin
                // Any request seen here is ignored; the CPU re-presents it.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Keep the slave side quiet while reset is held.
        if (rst) begin
            stall   = 1'b0;
            slv_sel = '0;
            slv_we  = 1'b0;
            rdata   = r_rdata_q;
            w_miss  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_rdata_q <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_miss;
            if (w_cap) r_rdata_q <= w_cap_data;
        end
    end

    always_ff @(posedge clk) begin
        r_sidx <= w_sidx_nxt;
    end

    assign err       = r_err;
    assign slv_addr  = addr;
    assign slv_wdata = wdata;

`ifdef CHIPSET_ERRCNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_err_cnt;
    logic        w_clr;

    // The counter moves on the same edge that raises err, so a clearing
    // write that is itself unmapped leaves the count at zero.
    assign w_clr = (r_state == S_IDLE) && req && we && addr[AW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_clr) begin
            r_err_cnt <= 16'd0;
        end else if (w_miss) begin
            r_err_cnt <= sat_inc16(r_err_cnt);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_chipset.sv
// ---------------------------------------------------------------------------
// tb_bus_chipset
//   Directed bench for bus_chipset with a cycle-level reference model of the
//   memory map (region table, stall countdown, captured read data, error
//   count) checked against the DUT on every falling edge, plus literal
//   expectations at key points of each directed transaction.
// ---------------------------------------------------------------------------
module tb_bus_chipset;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic [15:0] err_cnt;
    logic [2:0]  slv_sel;
    logic        slv_we;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [95:0] slv_rdata;

    logic [31:0] slvd [3];

    int tests = 0;
    int fails = 0;

    assign slv_rdata = {slvd[2], slvd[1], slvd[0]};

    bus_chipset dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .err_cnt   (err_cnt),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory map as address ranges: slave0 0x000-0x7FF (L=1),
    // slave1 0x800-0x87F (L=2), slave2 0x1000-0x1FFF (L=0).
    function automatic int m_slave(input logic [31:0] a);
        if (a < 32'h800) return 0;
        else if (a < 32'h880) return 1;
        else if (a >= 32'h1000 && a < 32'h2000) return 2;
        else return -1;
    endfunction

    function automatic int m_lat(input int s);
        case (s)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    // Reference model state
    bit          m_init = 0;
    int          m_left = 0;
    int          m_sidx = 0;
    bit          m_bub  = 0;
    bit          m_err  = 0;
    logic [31:0] m_q    = '0;
    logic [15:0] m_cnt  = '0;

    always @(negedge clk) begin
        logic [2:0]  e_sel;
        logic [31:0] e_rdata;
        logic [15:0] e_cnt;
        bit          e_stall, e_we, e_err;
        int          n_left, n_sidx, s, l;
        bit          n_bub, n_err;
        logic [31:0] n_q;
        logic [15:0] n_cnt;

        e_sel = '0; e_stall = 0; e_we = 0; e_rdata = m_q; e_err = m_err;
`ifdef CHIPSET_ERRCNT_EN
        e_cnt = m_cnt;
`else
        e_cnt = 16'h0;
`endif
        n_left = m_left; n_sidx = m_sidx; n_bub = 0; n_err = 0; n_q = m_q; n_cnt = m_cnt;

        if (rst) begin
            n_left = 0; n_q = '0; n_cnt = '0;
        end else if (m_bub) begin
            n_bub = 0;
        end else if (m_left > 0) begin
            if (!req) begin
                n_left = 0;
            end else begin
                e_stall = 1;
                e_sel[m_sidx] = 1'b1;
                n_left = m_left - 1;
                if (n_left == 0) begin
                    n_q = slvd[m_sidx];
                    n_bub = 1;
                end
            end
        end else if (req) begin
            s = m_slave(addr);
            if (s < 0) begin
                n_err = 1;
                if (!we) e_rdata = '0;
                if (we && addr[31]) n_cnt = '0;
                else if (m_cnt != 16'hFFFF) n_cnt = m_cnt + 16'd1;
            end else begin
                e_sel[s] = 1'b1;
                l = m_lat(s);
                if (we) begin
                    e_we = 1;
                end else if (l == 0) begin
                    e_rdata = slvd[s];
                end else begin
                    e_stall = 1;
                    n_sidx = s;
                    n_left = l - 1;
                    if (n_left == 0) begin
                        n_q = slvd[s];
                        n_bub = 1;
                    end
                end
            end
        end

        if (m_init) begin
            chk("m_stall",   stall,     e_stall);
            chk("m_sel",     slv_sel,   e_sel);
            chk("m_we",      slv_we,    e_we);
            chk("m_rdata",   rdata,     e_rdata);
            chk("m_err",     err,       e_err);
            chk("m_err_cnt", err_cnt,   e_cnt);
            chk("m_addr",    slv_addr,  addr);
            chk("m_wdata",   slv_wdata, wdata);
        end

        m_left = n_left; m_sidx = n_sidx; m_bub = n_bub; m_err = n_err;
        m_q = n_q; m_cnt = n_cnt;
        if (rst) m_init = 1;
    end

    task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; addr = a; wdata = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a read, hold it while stalled, count stall cycles (bounded).
    task automatic rd_stretch(input logic [31:0] a, input int exp_n,
                              input logic [31:0] exp_d, input string nm);
        int n;
        bit done;
        n = 0;
        done = 0;
        next_cycle();
        drive(1, 0, a, 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
            n++;
            next_cycle();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, expected release", nm, n);
        end else begin
            chk({nm, "_stalls"}, n, exp_n);
            chk({nm, "_rdata"}, rdata, exp_d);
        end
        next_cycle();
        drive(0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 32'h0, 32'h0);
        slvd[0] = 32'h1111_0000;
        slvd[1] = 32'h1234_5678;
        slvd[2] = 32'h0000_00A5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_sel", slv_sel, 3'b000);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'h0);

        // Write to slave0: single cycle, no stall
        next_cycle();
        drive(1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_sel", slv_sel, 3'b001);
        chk("wr_we", slv_we, 1'b1);
        chk("wr_stall", stall, 1'b0);
        chk("wr_wdata", slv_wdata, 32'hDEAD_BEEF);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wr_err", err, 1'b0);

        // Slave1 read, latency 2
        rd_stretch(32'h0000_0804, 2, 32'h1234_5678, "rd_s1");

        // Slave2 read, latency 0
        next_cycle();
        drive(1, 0, 32'h0000_1000, 32'h0);
        @(negedge clk);
        chk("rd0_stall", stall, 1'b0);
        chk("rd0_rdata", rdata, 32'h0000_00A5);
        chk("rd0_sel", slv_sel, 3'b100);

        // Unmapped read
        next_cycle();
        drive(1, 0, 32'h0000_2000, 32'h0);
        @(negedge clk);
        chk("miss_sel", slv_sel, 3'b000);
        chk("miss_rdata", rdata, 32'h0);
        chk("miss_stall", stall, 1'b0);
        chk("miss_err_early", err, 1'b0);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("miss_err", err, 1'b1);
`ifdef CHIPSET_ERRCNT_EN
        chk("miss_err_cnt", err_cnt, 16'd1);
`endif
        next_cycle();
        @(negedge clk);
        chk("miss_err_pulse", err, 1'b0);

        // Slave0 read, latency 1
        rd_stretch(32'h0000_0100, 1, 32'h1111_0000, "rd_s0");

        // Reset in the middle of a slave1 read
        next_cycle();
        drive(1, 0, 32'h0000_0804, 32'h0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstw_stall", stall, 1'b0);
        chk("rstw_sel", slv_sel, 3'b000);
        chk("rstw_rdata", rdata, 32'h0);
        chk("rstw_err_cnt", err_cnt, 16'h0);
        rd_stretch(32'h0000_0804, 2, 32'h1234_5678, "rd_after_rst");

        // Abort a slave1 read after its launch cycle
        slvd[1] = 32'hCAFE_F00D;
        next_cycle();
        drive(1, 0, 32'h0000_0808, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abort_stall", stall, 1'b0);
        chk("abort_sel", slv_sel, 3'b000);
        next_cycle();
        @(negedge clk);
        chk("abort_rdata", rdata, 32'h1234_5678);
        chk("abort_err", err, 1'b0);
        next_cycle();
        drive(1, 0, 32'h0000_1004, 32'h0);
        @(negedge clk);
        chk("abort_then_rd0", rdata, 32'h0000_00A5);

        // Three unmapped reads, then a clearing write (itself unmapped)
        next_cycle();
        drive(1, 0, 32'h0000_2000, 32'h0);
        next_cycle();
        drive(1, 0, 32'h0000_3000, 32'h0);
        next_cycle();
        drive(1, 0, 32'h0000_4000, 32'h0);
        next_cycle();
        drive(1, 1, 32'h8000_0000, 32'h0);
        @(negedge clk);
        chk("clr_err_prev", err, 1'b1);
`ifdef CHIPSET_ERRCNT_EN
        chk("clr_cnt_before", err_cnt, 16'd3);
`endif
        next_cycle();
        drive(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("clr_err_pulse", err, 1'b1);
        chk("clr_cnt_after", err_cnt, 16'd0);

        repeat (3) next_cycle();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not reach the end, expected completion");
        $fatal(1);
    end

endmodule
